debug_dump_sequencer: RTL and testbench
=======================================

// Module: debug_dump_sequencer
// PURPOSE
//   Sequences a full MIPS state dump to the host over the UART TX path after a halt or a debug
//   "dump" command. Drives the MIPS debug read-address ports (register bank, data memory),
//   captures each 32-bit word, and serializes it as SIZE_TRAMA-bit frames with a start/done
//   handshake. Sits between UnitDebug (command side) and the UART/TOP_MIPS debug ports.
// PARAMETERS
//   BITS_SIZE      32  data word width; also width of o_select_addr_memdata
//   SIZE_TRAMA     8   UART frame width; BITS_SIZE must be a multiple of it
//   NUM_REGS       32  register-bank entries dumped (addresses 0..NUM_REGS-1)
//   SIZE_MEM_DATA  16  data-memory words dumped (addresses 0..SIZE_MEM_DATA-1)
// PORTS
//   i_clk                    in   1               system clock (clk_wiz output)
//   i_reset                  in   1               synchronous, active-high reset
//   i_start                  in   1               1-cycle dump request; ignored while o_busy
//   i_pc                     in   BITS_SIZE       current MIPS PC
//   i_clk_count              in   BITS_SIZE       executed-cycle counter
//   i_data_register          in   BITS_SIZE       register-bank word at o_select_addr_registers
//   i_data_mem               in   BITS_SIZE       data-memory word at o_select_addr_memdata
//   i_tx_done                in   1               1-cycle pulse: UART finished current frame
//   o_select_addr_registers  out  clog2(NUM_REGS) register-bank read address
//   o_select_addr_memdata    out  BITS_SIZE       data-memory read address (word index)
//   o_tx_start               out  1               1-cycle pulse: send o_tx_data
//   o_tx_data                out  SIZE_TRAMA      frame to transmit; stable from o_tx_start to i_tx_done
//   o_busy                   out  1               high from accepted i_start until o_done
//   o_done                   out  1               1-cycle pulse after final frame's i_tx_done
// BEHAVIOUR
//   Reset: all outputs 0, FSM to IDLE, word/byte counters 0. Reset mid-dump aborts immediately.
//   Dump order (words): PC, clk_count, REG[0..NUM_REGS-1], MEM[0..SIZE_MEM_DATA-1];
//     total W = 2+NUM_REGS+SIZE_MEM_DATA (default 50 words, 200 frames).
//   Each word sent least-significant frame first, BITS_SIZE/SIZE_TRAMA frames per word.
//   FSM:
//     IDLE    : i_start -> SELECT, o_busy<=1, word_idx<=0.
//     SELECT  : drive address for word_idx (REG idx = word_idx-2, MEM idx = word_idx-2-NUM_REGS;
//               address held 0 for PC/clk_count words) -> CAPTURE.
//     CAPTURE : one cycle after SELECT (read-port settle); latch selected word into shift reg,
//               byte_idx<=0 -> SEND.
//     SEND    : o_tx_data<=shift[SIZE_TRAMA-1:0], o_tx_start=1 for exactly 1 cycle -> WAIT_TX.
//     WAIT_TX : hold o_tx_data; on i_tx_done: if byte_idx==last -> NEXT, else shift right by
//               SIZE_TRAMA, byte_idx++ -> SEND.
//     NEXT    : if word_idx==W-1 -> DONE, else word_idx++ -> SELECT.
//     DONE    : o_done=1 one cycle, o_busy<=0, addresses<=0 -> IDLE.
//   Latency: i_start to first o_tx_start = 3 cycles (SELECT, CAPTURE, SEND).
//   i_tx_done outside WAIT_TX is ignored. i_start during o_busy is ignored (no queuing).
//   i_start in the DONE cycle is ignored; accepted from the following IDLE cycle.
//   Captured word is frozen: changes on i_data_* after CAPTURE do not alter frames in flight.
//   No timeout: FSM waits in WAIT_TX indefinitely for i_tx_done.
//   Counters sized to hold W-1 and frames-per-word-1; no wrap inside a dump.
// TESTING
//   Reset, then idle 10 cycles -> all outputs 0, no o_tx_start.
//   i_pc=0x12345678, i_start, bench acks each frame 5 cycles later -> first 4 frames 78,56,34,12.
//   Register model REG[k]=k*0x01010101, MEM[k]=0xA0000000+k -> 200 frames in order; REG[31] sent
//     1F,1F,1F,1F; MEM[15] sent 0F,00,00,A0; o_done pulses once after 200th ack.
//   i_start pulses during dump and spurious i_tx_done in SELECT -> frame count/order unchanged.
//   i_reset asserted while waiting on frame 37 -> next cycle o_busy=0, o_tx_start=0; new i_start
//     restarts from PC word.
//   Change i_data_register during WAIT_TX of REG[3] -> remaining frames of REG[3] use latched value.

Source files
------------

// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: walks PC, cycle counter, register bank and data memory,
// capturing each word and streaming it to the UART TX path as SIZE_TRAMA-bit
// frames, least-significant frame first, with a start/done handshake per frame.
module debug_dump_sequencer #(
  parameter int unsigned BITS_SIZE     = 32,
  parameter int unsigned SIZE_TRAMA    = 8,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned SIZE_MEM_DATA = 16,
  localparam int unsigned RegAddrW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BITS_SIZE-1:0]  i_pc,
  input  logic [BITS_SIZE-1:0]  i_clk_count,
  input  logic [BITS_SIZE-1:0]  i_data_register,
  input  logic [BITS_SIZE-1:0]  i_data_mem,
  input  logic                  i_tx_done,
  output logic [RegAddrW-1:0]   o_select_addr_registers,
  output logic [BITS_SIZE-1:0]  o_select_addr_memdata,
  output logic                  o_tx_start,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned NumWords      = 2 + NUM_REGS + SIZE_MEM_DATA;
  localparam int unsigned FramesPerWord = BITS_SIZE / SIZE_TRAMA;
  localparam int unsigned WordIdxW      = $clog2(NumWords);
  localparam int unsigned ByteIdxW      = (FramesPerWord > 1) ? $clog2(FramesPerWord) : 1;

  localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(NumWords - 1);
  localparam logic [WordIdxW-1:0] FirstReg = WordIdxW'(2);
  localparam logic [WordIdxW-1:0] FirstMem = WordIdxW'(2 + NUM_REGS);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(FramesPerWord - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSelect  = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StSend    = 3'd3;
  localparam logic [2:0] StWaitTx  = 3'd4;
  localparam logic [2:0] StNext    = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  logic [2:0]           state_q,    state_d;
  logic [WordIdxW-1:0]  word_idx_q, word_idx_d;
  logic [ByteIdxW-1:0]  byte_idx_q, byte_idx_d;
  logic [BITS_SIZE-1:0] shift_q,    shift_d;
  logic                 busy_q,     busy_d;
  logic [RegAddrW-1:0]  reg_addr_q, reg_addr_d;
  logic [BITS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [BITS_SIZE-1:0] word_sel;

  // Pick the source of the current word; read ports have had a cycle to settle.
  always_comb begin
    word_sel = i_data_mem;
    if (word_idx_q == WordIdxW'(0)) begin
      word_sel = i_pc;
    end else if (word_idx_q == WordIdxW'(1)) begin
      word_sel = i_clk_count;
    end else if (word_idx_q < FirstMem) begin
      word_sel = i_data_register;
    end
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d    = StSelect;
          busy_d     = 1'b1;
          word_idx_d = '0;
        end
      end

      StSelect: begin
        // Only the port owning the current word gets a non-zero address.
        reg_addr_d = '0;
        mem_addr_d = '0;
        if (word_idx_q >= FirstMem) begin
          mem_addr_d = BITS_SIZE'(word_idx_q - FirstMem);
        end else if (word_idx_q >= FirstReg) begin
          reg_addr_d = RegAddrW'(word_idx_q - FirstReg);
        end
        state_d = StCapture;
      end

      StCapture: begin
        // Word is frozen here; later input changes cannot alter frames in flight.
        shift_d    = word_sel;
        byte_idx_d = '0;
        state_d    = StSend;
      end

      StSend: begin
        state_d = StWaitTx;
      end

      StWaitTx: begin
        if (i_tx_done) begin
          if (byte_idx_q == LastByte) begin
            state_d = StNext;
          end else begin
            shift_d    = shift_q >> SIZE_TRAMA;
            byte_idx_d = byte_idx_q + ByteIdxW'(1);
            state_d    = StSend;
          end
        end
      end

      StNext: begin
        if (word_idx_q == LastWord) begin
          state_d = StDone;
        end else begin
          word_idx_d = word_idx_q + WordIdxW'(1);
          state_d    = StSelect;
        end
      end

      StDone: begin
        busy_d     = 1'b0;
        reg_addr_d = '0;
        mem_addr_d = '0;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any dump in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Outputs: frame data is the low slice of the shift register, held through WAIT_TX.
  always_comb begin
    o_select_addr_registers = reg_addr_q;
    o_select_addr_memdata   = mem_addr_q;
    o_tx_data               = shift_q[SIZE_TRAMA-1:0];
    o_tx_start              = (state_q == StSend);
    o_done                  = (state_q == StDone);
    o_busy                  = busy_q;
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench for debug_dump_sequencer: a frame-level reference model
// (list of words -> byte queue) compared against randomized dumps with random
// ack delays, stray start/done pulses, mid-dump reset and input changes in flight.
module tb_debug_dump_sequencer;

  localparam int NR = 32;
  localparam int NM = 16;
  localparam int NW = 2 + NR + NM;
  localparam int NF = NW * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tx_done;
  logic [31:0] pc;
  logic [31:0] clk_count;
  logic [31:0] data_reg;
  logic [31:0] data_mem;
  logic [4:0]  reg_addr;
  logic [31:0] mem_addr;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  logic [31:0] reg_m [NR];
  logic [31:0] mem_m [NM];
  bit          reg_override;
  logic [7:0]  exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural read ports driven by the bench's memory model.
  assign data_reg = reg_override ? 32'hDEADBEEF : reg_m[reg_addr];
  assign data_mem = (mem_addr < 32'(NM)) ? mem_m[mem_addr[3:0]] : 32'hBAD0BAD0;

  debug_dump_sequencer dut (
    .i_clk                   (clk),
    .i_reset                 (rst),
    .i_start                 (start),
    .i_pc                    (pc),
    .i_clk_count             (clk_count),
    .i_data_register         (data_reg),
    .i_data_mem              (data_mem),
    .i_tx_done               (tx_done),
    .o_select_addr_registers (reg_addr),
    .o_select_addr_memdata   (mem_addr),
    .o_tx_start              (tx_start),
    .o_tx_data               (tx_data),
    .o_busy                  (busy),
    .o_done                  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Expected frame stream: word list in dump order, each split LS byte first.
  function automatic void build_expected();
    logic [31:0] w [$];
    exp_q.delete();
    w.push_back(pc);
    w.push_back(clk_count);
    for (int k = 0; k < NR; k++) w.push_back(reg_m[k]);
    for (int k = 0; k < NM; k++) w.push_back(mem_m[k]);
    foreach (w[i]) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((w[i] >> (8 * b)) & 32'hFF));
    end
  endfunction

  task automatic randomize_model();
    pc        = $urandom;
    clk_count = $urandom;
    for (int k = 0; k < NR; k++) reg_m[k] = $urandom;
    for (int k = 0; k < NM; k++) mem_m[k] = $urandom;
  endtask

  task automatic fixed_model();
    for (int k = 0; k < NR; k++) reg_m[k] = 32'(k) * 32'h01010101;
    for (int k = 0; k < NM; k++) mem_m[k] = 32'hA0000000 + 32'(k);
  endtask

  // One dump: abort_at >= 0 resets while waiting on that frame; corrupt_word >= 0
  // changes the register read data while that word's frames are in flight.
  task automatic run_dump(input string name, input int abort_at, input bit chaos,
                          input int corrupt_word);
    int cycles;
    int delay;
    int done_seen;
    int done_at;
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    for (int f = 0; f < NF; f++) begin
      while (!tx_start && cycles < 40) begin
        @(negedge clk);
        cycles++;
        start   = chaos ? 1'($urandom_range(0, 1)) : 1'b0;
        // Cycles 1..3 after an ack (or start) are never WAIT_TX.
        tx_done = (chaos && cycles <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start   = 1'b0;
      tx_done = 1'b0;
      if (!tx_start) begin
        check($sformatf("%s tx_start timeout frame %0d", name, f), 32'd0, 32'd1);
        return;
      end
      if (f == 0) check($sformatf("%s start latency", name), 32'(cycles), 32'd3);
      check($sformatf("%s frame %0d", name, f), 32'(tx_data), 32'(exp_q[f]));
      if (f == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("%s busy after reset", name), 32'(busy), 32'd0);
        check($sformatf("%s tx_start after reset", name), 32'(tx_start), 32'd0);
        check($sformatf("%s done after reset", name), 32'(done), 32'd0);
        return;
      end
      if (corrupt_word >= 0 && f == corrupt_word * 4) reg_override = 1'b1;
      delay = chaos ? $urandom_range(1, 6) : 5;
      @(negedge clk);
      check($sformatf("%s tx_start width frame %0d", name, f), 32'(tx_start), 32'd0);
      repeat (delay - 1) @(negedge clk);
      check($sformatf("%s tx_data hold frame %0d", name, f), 32'(tx_data), 32'(exp_q[f]));
      tx_done = 1'b1;
      if (corrupt_word >= 0 && f == corrupt_word * 4 + 3) reg_override = 1'b0;
      @(negedge clk);
      tx_done = chaos ? 1'($urandom_range(0, 1)) : 1'b0;
      cycles  = 1;
    end
    done_seen = 0;
    done_at   = 0;
    if (done) begin
      done_seen++;
      done_at = 1;
    end
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (done) begin
        done_seen++;
        done_at = i;
      end
    end
    check($sformatf("%s done pulse count", name), 32'(done_seen), 32'd1);
    check($sformatf("%s done timing", name), 32'(done_at), 32'd2);
    check($sformatf("%s busy after done", name), 32'(busy), 32'd0);
    check($sformatf("%s tx_start after done", name), 32'(tx_start), 32'd0);
  endtask

  initial begin
    int n_starts;
    int n_nonzero;
    rst          = 1'b1;
    start        = 1'b0;
    tx_done      = 1'b0;
    pc           = '0;
    clk_count    = '0;
    reg_override = 1'b0;
    fixed_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    n_starts  = 0;
    n_nonzero = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) n_starts++;
      if (busy || done || tx_data != 8'h00 || reg_addr != 5'd0 || mem_addr != 32'd0)
        n_nonzero++;
    end
    check("idle tx_start count", 32'(n_starts), 32'd0);
    check("idle outputs nonzero", 32'(n_nonzero), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    pc        = 32'h12345678;
    clk_count = $urandom;
    fixed_model();
    run_dump("fixed", -1, 1'b0, -1);

    randomize_model();
    run_dump("chaos", -1, 1'b1, -1);

    randomize_model();
    run_dump("abort", 36, 1'b0, -1);
    pc = $urandom;
    run_dump("restart", -1, 1'b1, -1);

    pc        = $urandom;
    clk_count = $urandom;
    fixed_model();
    run_dump("latch", -1, 1'b0, 5);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
